otter_mem_arbiter: RTL and testbench
====================================

OTTER_MEM_ARBITER -- requirements
Module: otter_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_STREAK, default 4: the number of consecutive DATA grants allowed while IF waits (range 1..15).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have per-requester ports for X in {IF, DATA, PROG}:
- X_REQ  input  1  access request.
- X_ADDR  input  32  byte address.
- X_WE  input  1  write enable.
- X_WDATA  input  32  write data.
- X_SIZE  input  2  access size.
- X_SIGN  input  1  sign-extend flag.
- X_GNT  output  1  request accepted this cycle.
- X_RVALID  output  1  read data valid this cycle.
REQ-005 SHALL have port RDATA  output  32  read data, shared by all requesters and qualified by X_RVALID.
REQ-006 SHALL have memory-side ports:
- M_ADDR  output  32  address.
- M_WDATA  output  32  write data.
- M_SIZE  output  2  size.
- M_SIGN  output  1  sign.
- M_WE  output  1  write enable.
- M_RE  output  1  read enable.
- M_RDATA  input  32  read data, valid 1 cycle after M_RE.
REQ-007 SHALL have port STALL_IF  output  1  equal to IF_REQ & ~IF_GNT.
REQ-008 SHALL have port STALL_DATA  output  1  equal to DATA_REQ & ~DATA_GNT.

Function
REQ-009 SHALL implement an FSM with states RUN and PROG.
REQ-010 In RUN, fixed priority SHALL be PROG > DATA > IF, except as modified by REQ-014.
REQ-011 Grant SHALL be combinational; M_* SHALL mux the granted requester's fields in the same cycle.
REQ-012 With no grant, M_WE and M_RE SHALL be 0 and M_ADDR, M_WDATA, M_SIZE and M_SIGN SHALL be 0.
REQ-013 M_RE SHALL equal the grant & ~X_WE; M_WE SHALL equal the grant & X_WE.
REQ-014 A streak counter of width 4 SHALL increment on each DATA grant while IF_REQ=1 and clear on an IF grant or when IF_REQ=0. At count == MAX_DATA_STREAK, IF SHALL win over DATA for one cycle, then the counter clears.
REQ-015 A PROG grant in RUN SHALL move the FSM to PROG on the next edge. In PROG, only PROG is granted; IF_GNT and DATA_GNT SHALL be 0.
REQ-016 In PROG, the first cycle with PROG_REQ=0 SHALL return the FSM to RUN on the next edge, with the streak counter cleared.
REQ-017 A one-deep response tag (owner: NONE/IF/DATA/PROG) SHALL register the owner of each granted read. The cycle after, RVALID SHALL be asserted to that owner only and RDATA SHALL equal M_RDATA.
REQ-018 Writes SHALL never raise RVALID.
REQ-019 Back-to-back reads SHALL sustain 1 grant per cycle, with the response tag overwritten every cycle.
REQ-020 A read outstanding when entering PROG SHALL still deliver its RVALID to its original owner.
REQ-021 Requests SHALL not be queued: an ungranted requester holds its fields until X_GNT.

Reset
REQ-022 On RESET_N=0, asynchronously: state=RUN, streak=0, response tag=NONE, all X_RVALID=0.
REQ-023 Reset asserted with a read outstanding SHALL drop that response; no RVALID after release.
REQ-024 Grant outputs during reset SHALL be forced 0; M_WE and M_RE SHALL be 0.

Configuration
REQ-025 Macro OTTER_ARB_FAIRNESS_EN defined: the streak counter and REQ-014 SHALL be present.
REQ-026 Macro OTTER_ARB_FAIRNESS_EN undefined: the counter SHALL be absent, strict priority SHALL apply and IF may starve indefinitely; MAX_DATA_STREAK is ignored.

Structure
REQ-027 Package otter_arb_pkg SHALL hold the typedefs arb_state_t (RUN, PROG) and arb_owner_t (NONE, IF, DATA, PROG) and the size constants BYTE/HALF/WORD.
REQ-028 The streak counter SHALL be sub-module otter_arb_streak, instantiated only under OTTER_ARB_FAIRNESS_EN.

Verification
REQ-029 IF_REQ=1 alone, read of addr 0x100, M_RDATA=0xDEADBEEF -> IF_GNT=1 with M_RE=1 and M_ADDR=0x100 in cycle 0; IF_RVALID=1 with RDATA=0xDEADBEEF in cycle 1.
REQ-030 IF_REQ=1 and DATA_REQ=1 (write 0x55 to 0x2000) in the same cycle -> DATA_GNT=1, M_WE=1, STALL_IF=1; no RVALID next cycle.
REQ-031 Fairness on, IF_REQ and DATA_REQ held for 6 cycles -> DATA granted in cycles 0-3, IF in cycle 4, DATA in cycle 5.
REQ-032 PROG_REQ rises while DATA_REQ is held -> PROG_GNT=1, FSM=PROG; DATA_GNT=0 until 1 cycle after PROG_REQ falls, then DATA_GNT=1.
REQ-033 RESET_N pulsed low in the cycle after a DATA read grant -> DATA_RVALID=0; state=RUN; first request after release is granted normally.
REQ-034 Fairness off, IF_REQ and DATA_REQ held for 20 cycles -> IF_GNT=0 throughout and STALL_IF=1 throughout.

Source files
------------

// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER memory arbiter.
// Owner tags carry an OWN_ prefix so they do not collide with the PROG state name.
package otter_arb_pkg;

  typedef enum logic {
    RUN,
    PROG
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DATA,
    OWN_PROG
  } arb_owner_t;

  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd2;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/otter_arb_streak.sv
// Counts consecutive DATA grants while IF is waiting; raises limit when IF must win.
// Instantiated only when OTTER_ARB_FAIRNESS_EN is defined.
module otter_arb_streak
  import otter_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clr,
  input  logic inc,
  output logic limit
);

  logic [STREAK_W-1:0] count_reg, count_next;

  // Clear dominates; saturate so a wide MAX can never wrap back to zero.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != {STREAK_W{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign limit = (count_reg == STREAK_W'(MAX_DATA_STREAK));

endmodule

// File: rtl/otter_mem_arbiter.sv
// Three-way memory arbiter (PROG > DATA > IF) with a one-deep read response tag.
// Define OTTER_ARB_FAIRNESS_EN to bound how long DATA may starve IF.
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  input  logic        IF_WE,
  input  logic [31:0] IF_WDATA,
  input  logic [1:0]  IF_SIZE,
  input  logic        IF_SIGN,
  output logic        IF_GNT,
  output logic        IF_RVALID,
  input  logic        DATA_REQ,
  input  logic [31:0] DATA_ADDR,
  input  logic        DATA_WE,
  input  logic [31:0] DATA_WDATA,
  input  logic [1:0]  DATA_SIZE,
  input  logic        DATA_SIGN,
  output logic        DATA_GNT,
  output logic        DATA_RVALID,
  input  logic        PROG_REQ,
  input  logic [31:0] PROG_ADDR,
  input  logic        PROG_WE,
  input  logic [31:0] PROG_WDATA,
  input  logic [1:0]  PROG_SIZE,
  input  logic        PROG_SIGN,
  output logic        PROG_GNT,
  output logic        PROG_RVALID,
  output logic [31:0] RDATA,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  output logic [1:0]  M_SIZE,
  output logic        M_SIGN,
  output logic        M_WE,
  output logic        M_RE,
  input  logic [31:0] M_RDATA,
  output logic        STALL_IF,
  output logic        STALL_DATA
);

  arb_state_t state_reg, state_next;
  arb_owner_t tag_reg, tag_next;
  logic       streak_limit;

  if ((MAX_DATA_STREAK < 1) || (MAX_DATA_STREAK > 15)) begin : g_bad_streak
    $error("MAX_DATA_STREAK must be in 1..15");
  end

  // Grants are gated by RESET_N so nothing reaches memory while reset is held.
  always_comb begin
    IF_GNT   = 1'b0;
    DATA_GNT = 1'b0;
    PROG_GNT = 1'b0;
    if (RESET_N) begin
      if (state_reg == PROG) begin
        PROG_GNT = PROG_REQ;
      end else if (PROG_REQ) begin
        PROG_GNT = 1'b1;
      end else if (DATA_REQ && !(IF_REQ && streak_limit)) begin
        DATA_GNT = 1'b1;
      end else if (IF_REQ) begin
        IF_GNT = 1'b1;
      end
    end
  end

  always_comb begin
    M_ADDR  = '0;
    M_WDATA = '0;
    M_SIZE  = '0;
    M_SIGN  = 1'b0;
    M_WE    = 1'b0;
    M_RE    = 1'b0;
    tag_next = OWN_NONE;
    if (PROG_GNT) begin
      M_ADDR = PROG_ADDR;  M_WDATA = PROG_WDATA;
      M_SIZE = PROG_SIZE;  M_SIGN  = PROG_SIGN;
      M_WE   = PROG_WE;    M_RE    = ~PROG_WE;
      if (!PROG_WE) tag_next = OWN_PROG;
    end else if (DATA_GNT) begin
      M_ADDR = DATA_ADDR;  M_WDATA = DATA_WDATA;
      M_SIZE = DATA_SIZE;  M_SIGN  = DATA_SIGN;
      M_WE   = DATA_WE;    M_RE    = ~DATA_WE;
      if (!DATA_WE) tag_next = OWN_DATA;
    end else if (IF_GNT) begin
      M_ADDR = IF_ADDR;    M_WDATA = IF_WDATA;
      M_SIZE = IF_SIZE;    M_SIGN  = IF_SIGN;
      M_WE   = IF_WE;      M_RE    = ~IF_WE;
      if (!IF_WE) tag_next = OWN_IF;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (PROG_GNT) state_next = PROG;
      PROG:    if (!PROG_REQ) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= RUN;
      tag_reg   <= OWN_NONE;
    end else begin
      state_reg <= state_next;
      tag_reg   <= tag_next;
    end
  end

`ifdef OTTER_ARB_FAIRNESS_EN
  logic streak_clr;
  logic streak_inc;

  // Leaving PROG also restarts the streak so IF is not penalised by pre-PROG history.
  assign streak_clr = ~IF_REQ | IF_GNT | ((state_reg == PROG) & ~PROG_REQ);
  assign streak_inc = DATA_GNT & IF_REQ;

  otter_arb_streak #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_streak (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .clr    (streak_clr),
    .inc    (streak_inc),
    .limit  (streak_limit)
  );
`else
  assign streak_limit = 1'b0;
`endif

  assign IF_RVALID   = (tag_reg == OWN_IF);
  assign DATA_RVALID = (tag_reg == OWN_DATA);
  assign PROG_RVALID = (tag_reg == OWN_PROG);
  assign RDATA       = M_RDATA;

  assign STALL_IF   = IF_REQ & ~IF_GNT;
  assign STALL_DATA = DATA_REQ & ~DATA_GNT;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter: grants are checked in-line, read responses via a scoreboard queue.
module tb_otter_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        IF_REQ, IF_WE, IF_SIGN, DATA_REQ, DATA_WE, DATA_SIGN, PROG_REQ, PROG_WE, PROG_SIGN;
  logic [31:0] IF_ADDR, IF_WDATA, DATA_ADDR, DATA_WDATA, PROG_ADDR, PROG_WDATA;
  logic [1:0]  IF_SIZE, DATA_SIZE, PROG_SIZE;
  logic        IF_GNT, IF_RVALID, DATA_GNT, DATA_RVALID, PROG_GNT, PROG_RVALID;
  logic [31:0] RDATA, M_ADDR, M_WDATA;
  logic [1:0]  M_SIZE;
  logic        M_SIGN, M_WE, M_RE;
  logic [31:0] M_RDATA = 32'd0;
  logic        STALL_IF, STALL_DATA;

  otter_mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_WE(IF_WE), .IF_WDATA(IF_WDATA),
    .IF_SIZE(IF_SIZE), .IF_SIGN(IF_SIGN), .IF_GNT(IF_GNT), .IF_RVALID(IF_RVALID),
    .DATA_REQ(DATA_REQ), .DATA_ADDR(DATA_ADDR), .DATA_WE(DATA_WE), .DATA_WDATA(DATA_WDATA),
    .DATA_SIZE(DATA_SIZE), .DATA_SIGN(DATA_SIGN), .DATA_GNT(DATA_GNT), .DATA_RVALID(DATA_RVALID),
    .PROG_REQ(PROG_REQ), .PROG_ADDR(PROG_ADDR), .PROG_WE(PROG_WE), .PROG_WDATA(PROG_WDATA),
    .PROG_SIZE(PROG_SIZE), .PROG_SIGN(PROG_SIGN), .PROG_GNT(PROG_GNT), .PROG_RVALID(PROG_RVALID),
    .RDATA(RDATA), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_SIZE(M_SIZE), .M_SIGN(M_SIGN),
    .M_WE(M_WE), .M_RE(M_RE), .M_RDATA(M_RDATA), .STALL_IF(STALL_IF), .STALL_DATA(STALL_DATA)
  );

  always #5 CLK = ~CLK;

  // Memory: data valid one cycle after M_RE; 0x100 holds DEADBEEF, elsewhere {addr[15:0], C0DE}.
  always @(posedge CLK) begin
    if (M_RE) M_RDATA <= (M_ADDR == 32'h100) ? 32'hDEADBEEF : {M_ADDR[15:0], 16'hC0DE};
  end

  typedef struct packed {
    logic [2:0]  who;   // {PROG, DATA, IF}
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [2:0] who, input logic [31:0] data);
    exp_t e;
    e.who  = who;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Response monitor: any RVALID must match the oldest expected read.
  always @(negedge CLK) begin
    logic [2:0] rv;
    exp_t       e;
    rv = {PROG_RVALID, DATA_RVALID, IF_RVALID};
    if (rv != 3'b000) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", {29'd0, rv}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_owner", {29'd0, rv}, {29'd0, e.who});
        chk("rsp_data", RDATA, e.data);
        $display("t=%0t rsp owner=%b rdata=%h", $time, rv, RDATA);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic idle();
    IF_REQ = 1'b0; DATA_REQ = 1'b0; PROG_REQ = 1'b0;
  endtask

  task automatic set_if(input logic [31:0] a, input logic we);
    IF_REQ = 1'b1; IF_ADDR = a; IF_WE = we;
  endtask

  task automatic set_data(input logic [31:0] a, input logic we, input logic [31:0] wd);
    DATA_REQ = 1'b1; DATA_ADDR = a; DATA_WE = we; DATA_WDATA = wd;
  endtask

  task automatic set_prog(input logic [31:0] a, input logic we, input logic [31:0] wd);
    PROG_REQ = 1'b1; PROG_ADDR = a; PROG_WE = we; PROG_WDATA = wd;
  endtask

`ifdef OTTER_ARB_FAIRNESS_EN
  localparam int FAIR_CYCLES = 6;
`else
  localparam int FAIR_CYCLES = 20;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_if;
    RESET_N = 1'b0;
    idle();
    IF_ADDR = 0; IF_WE = 0; IF_WDATA = 0; IF_SIZE = 2'd2; IF_SIGN = 0;
    DATA_ADDR = 0; DATA_WE = 0; DATA_WDATA = 0; DATA_SIZE = 2'd2; DATA_SIGN = 0;
    PROG_ADDR = 0; PROG_WE = 0; PROG_WDATA = 0; PROG_SIZE = 2'd2; PROG_SIGN = 0;
    set_if(32'h100, 1'b0);
    sample();
    chk("rst_if_gnt", {31'd0, IF_GNT}, 32'd0);
    chk("rst_m_re", {31'd0, M_RE}, 32'd0);
    chk("rst_rvalid", {29'd0, PROG_RVALID, DATA_RVALID, IF_RVALID}, 32'd0);

    step(); RESET_N = 1'b1; idle();
    sample();
    chk("idle_m_addr", M_ADDR, 32'd0);

    // Single IF read
    step(); set_if(32'h100, 1'b0);
    sample();
    chk("if_gnt", {31'd0, IF_GNT}, 32'd1);
    chk("if_m_re", {31'd0, M_RE}, 32'd1);
    chk("if_m_addr", M_ADDR, 32'h100);
    push(3'b001, 32'hDEADBEEF);
    $display("t=%0t if read 0x100", $time);

    // DATA write beats IF; no response follows
    step(); set_if(32'h104, 1'b0); set_data(32'h2000, 1'b1, 32'h55);
    DATA_SIZE = 2'd1; DATA_SIGN = 1'b1;
    sample();
    chk("wr_data_gnt", {31'd0, DATA_GNT}, 32'd1);
    chk("wr_m_we", {31'd0, M_WE}, 32'd1);
    chk("wr_m_re", {31'd0, M_RE}, 32'd0);
    chk("wr_stall_if", {31'd0, STALL_IF}, 32'd1);
    chk("wr_m_wdata", M_WDATA, 32'h55);
    chk("wr_m_size", {30'd0, M_SIZE}, 32'd1);
    chk("wr_m_sign", {31'd0, M_SIGN}, 32'd1);
    $display("t=%0t data write 0x2000", $time);
    step(); idle(); DATA_SIZE = 2'd2; DATA_SIGN = 1'b0;
    sample();
    chk("wr_no_rvalid", {29'd0, PROG_RVALID, DATA_RVALID, IF_RVALID}, 32'd0);

    // Back-to-back reads with changing owner
    step(); set_data(32'h10, 1'b0, 0); sample();
    chk("b2b0_gnt", {31'd0, DATA_GNT}, 32'd1); push(3'b010, 32'h0010C0DE);
    step(); set_data(32'h14, 1'b0, 0); sample();
    chk("b2b1_gnt", {31'd0, DATA_GNT}, 32'd1); push(3'b010, 32'h0014C0DE);
    step(); idle(); set_if(32'h20, 1'b0); sample();
    chk("b2b2_gnt", {31'd0, IF_GNT}, 32'd1); push(3'b001, 32'h0020C0DE);
    step(); idle(); set_data(32'h24, 1'b0, 0); sample();
    chk("b2b3_gnt", {31'd0, DATA_GNT}, 32'd1); push(3'b010, 32'h0024C0DE);
    step(); idle(); sample();

    // IF and DATA contending
    step(); set_if(32'h30, 1'b0); set_data(32'h40, 1'b0, 0);
    for (int i = 0; i < FAIR_CYCLES; i++) begin
      sample();
      exp_if = 1'b0;
`ifdef OTTER_ARB_FAIRNESS_EN
      exp_if = (i == 4);
`endif
      chk($sformatf("fair%0d_if_gnt", i), {31'd0, IF_GNT}, {31'd0, exp_if});
      chk($sformatf("fair%0d_data_gnt", i), {31'd0, DATA_GNT}, {31'd0, ~exp_if});
      chk($sformatf("fair%0d_stall_if", i), {31'd0, STALL_IF}, {31'd0, ~exp_if});
      if (exp_if) push(3'b001, 32'h0030C0DE);
      else        push(3'b010, 32'h0040C0DE);
      $display("t=%0t contend cycle %0d", $time, i);
      step();
    end
    idle(); sample();

    // PROG takes over while DATA is held; earlier reads still complete
    step(); set_data(32'h50, 1'b0, 0); sample();
    chk("pg_a_data_gnt", {31'd0, DATA_GNT}, 32'd1); push(3'b010, 32'h0050C0DE);
    step(); set_prog(32'h8000, 1'b0, 0); set_if(32'h30, 1'b0); sample();
    chk("pg_b_prog_gnt", {31'd0, PROG_GNT}, 32'd1);
    chk("pg_b_data_gnt", {31'd0, DATA_GNT}, 32'd0);
    chk("pg_b_stall_data", {31'd0, STALL_DATA}, 32'd1);
    chk("pg_b_m_addr", M_ADDR, 32'h8000);
    push(3'b100, 32'h8000C0DE);
    step(); set_prog(32'h8004, 1'b1, 32'hCAFE); sample();
    chk("pg_c_prog_gnt", {31'd0, PROG_GNT}, 32'd1);
    chk("pg_c_m_we", {31'd0, M_WE}, 32'd1);
    chk("pg_c_others", {30'd0, IF_GNT, DATA_GNT}, 32'd0);
    step(); PROG_REQ = 1'b0; sample();
    chk("pg_d_gnts", {29'd0, PROG_GNT, DATA_GNT, IF_GNT}, 32'd0);
    chk("pg_d_mem", {30'd0, M_WE, M_RE}, 32'd0);
    step(); sample();
    chk("pg_e_data_gnt", {31'd0, DATA_GNT}, 32'd1); push(3'b010, 32'h0050C0DE);
    step(); DATA_REQ = 1'b0; sample();
    chk("pg_f_if_gnt", {31'd0, IF_GNT}, 32'd1); push(3'b001, 32'h0030C0DE);
    step(); idle(); sample();

    // Reset drops an outstanding read
    step(); set_data(32'h60, 1'b0, 0); sample();
    chk("rs_data_gnt", {31'd0, DATA_GNT}, 32'd1);
    step(); RESET_N = 1'b0; idle(); set_if(32'h70, 1'b0); sample();
    chk("rs_data_rvalid", {31'd0, DATA_RVALID}, 32'd0);
    chk("rs_if_gnt", {31'd0, IF_GNT}, 32'd0);
    chk("rs_m_re", {31'd0, M_RE}, 32'd0);
    step(); RESET_N = 1'b1; idle(); set_data(32'h64, 1'b0, 0); sample();
    chk("rs_after_gnt", {31'd0, DATA_GNT}, 32'd1); push(3'b010, 32'h0064C0DE);
    step(); idle(); sample();
    step(); sample();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
